// File: rtl/i2c_req_arbiter_if.sv
// Handshake bundle between the two requesters, the serial I2C engine and the arbiter.
// The arbiter connects through the slave modport; requesters and engine use master.
interface i2c_req_arbiter_if;
    logic        req0;
    logic        req1;
    logic [23:0] data0;
    logic [23:0] data1;
    logic        done0;
    logic        done1;
    logic        ok0;
    logic        ok1;
    logic        mgo;
    logic [23:0] i2c_data;
    logic        mend;
    logic        mack;
    logic        busy;
    logic        grant;
    logic [7:0]  err_count;

    modport slave (
        input  req0, req1, data0, data1, mend, mack,
        output done0, done1, ok0, ok1, mgo, i2c_data, busy, grant, err_count
    );

    modport master (
        output req0, req1, data0, data1, mend, mack,
        input  done0, done1, ok0, ok1, mgo, i2c_data, busy, grant, err_count
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C transfer engine between two requesters,
// with NACK/timeout retry and per-transaction done/ok reporting.
module i2c_req_arbiter #(
    parameter int RETRY_MAX = 3,
    parameter int TIMEOUT   = 4095,
    parameter int TW        = 12
) (
    input  logic             clk,
    input  logic             reset,
    i2c_req_arbiter_if.slave bus
);
    localparam int RW = $clog2(RETRY_MAX + 2);

    typedef enum logic [1:0] {IDLE, WAIT, GAP, REPORT} state_t;

    state_t         state_q;
    logic [RW-1:0]  retry_q;
    logic [TW-1:0]  tmo_q;
    logic           rr_last_q;
    logic           mgo_q;
    logic           busy_q;
    logic           grant_q;
    logic           done0_q;
    logic           done1_q;
    logic           ok0_q;
    logic           ok1_q;
    logic [23:0]    data_q;
    logic [7:0]     err_q;

    logic           any_req_d;
    logic           pick_d;
    logic           timeout_d;
    logic           attempt_fail_d;
    logic           can_retry_d;

    always_comb begin
        any_req_d      = bus.req0 | bus.req1;
        // On a tie the requester that was not served last wins.
        pick_d         = (bus.req0 & bus.req1) ? ~rr_last_q : bus.req1;
        timeout_d      = (tmo_q == TW'(TIMEOUT - 1));
        attempt_fail_d = bus.mend ? ~bus.mack : timeout_d;
        can_retry_d    = (retry_q < RW'(RETRY_MAX));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            retry_q   <= '0;
            tmo_q     <= '0;
            rr_last_q <= 1'b1;
            mgo_q     <= 1'b0;
            busy_q    <= 1'b0;
            grant_q   <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            ok0_q     <= 1'b0;
            ok1_q     <= 1'b0;
            data_q    <= '0;
            err_q     <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            ok0_q   <= 1'b0;
            ok1_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        grant_q <= pick_d;
                        data_q  <= pick_d ? bus.data1 : bus.data0;
                        mgo_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        retry_q <= '0;
                        tmo_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (bus.mend && bus.mack) begin
                        mgo_q   <= 1'b0;
                        done0_q <= ~grant_q;
                        done1_q <= grant_q;
                        ok0_q   <= ~grant_q;
                        ok1_q   <= grant_q;
                        state_q <= REPORT;
                    end else if (attempt_fail_d) begin
                        mgo_q <= 1'b0;
                        if (can_retry_d) begin
                            retry_q <= retry_q + RW'(1);
                            state_q <= GAP;
                        end else begin
                            done0_q <= ~grant_q;
                            done1_q <= grant_q;
                            if (err_q != 8'hFF) begin
                                err_q <= err_q + 8'd1;
                            end
                            state_q <= REPORT;
                        end
                    end
                end
                GAP: begin
                    // One low cycle lets the engine re-arm before the retry.
                    mgo_q   <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end
                REPORT: begin
                    rr_last_q <= grant_q;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mgo       = mgo_q;
    assign bus.busy      = busy_q;
    assign bus.grant     = grant_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.ok0       = ok0_q;
    assign bus.ok1       = ok1_q;
    assign bus.i2c_data  = data_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: table rows, hand-written corner sequences and random
// transactions checked against a rule-level model of arbitration and retry.
module tb_i2c_req_arbiter;
    localparam int RETRY = 3;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    i2c_req_arbiter_if ifa ();
    i2c_req_arbiter_if ifb ();

    i2c_req_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    i2c_req_arbiter #(.RETRY_MAX(3), .TIMEOUT(16), .TW(5)) u_dut_tmo (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    typedef struct {
        bit          r0;
        bit          r1;
        logic [23:0] d0;
        logic [23:0] d1;
        int          nk;
        bit          eg;
        bit          eok;
        int          eatt;
        int          eerr;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: answers each mgo attempt after eng_delay cycles, NACKing while nacks_left > 0.
    int eng_delay  = 20;
    int nacks_left = 0;
    initial begin
        ifa.mend = 1'b0;
        ifa.mack = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.mgo && !reset) begin
                repeat (eng_delay - 1) @(negedge clk);
                ifa.mack = (nacks_left == 0);
                if (nacks_left > 0) nacks_left--;
                ifa.mend = 1'b1;
                @(negedge clk);
                ifa.mend = 1'b0;
                ifa.mack = 1'b0;
            end
        end
    end

    // Monitor sampled mid-high phase: attempts, gap widths, first word, done pulses.
    int          rises = 0;
    int          gap_bad = 0;
    int          low_len = 0;
    int          done0_cnt = 0;
    int          done1_cnt = 0;
    int          rise_cyc = 0;
    logic        mgo_prev = 1'b0;
    logic [23:0] first_data = '0;
    always begin
        @(posedge clk);
        #5;
        if (ifa.mgo && !mgo_prev) begin
            if (rises > 0 && low_len != 1) gap_bad++;
            if (rises == 0) begin
                first_data = ifa.i2c_data;
                rise_cyc   = cyc;
            end
            rises++;
        end
        low_len = ifa.mgo ? 0 : low_len + 1;
        if (ifa.done0) done0_cnt++;
        if (ifa.done1) done1_cnt++;
        mgo_prev = ifa.mgo;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ifa.done0 || ifa.done1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // One arbitration round; when both request, the loser is served right after with an ACK.
    task automatic txn(input bit r0, input bit r1, input logic [23:0] d0, input logic [23:0] d1,
                       input int nk, input bit eg, input bit eok, input int eatt, input int eerr);
        bit got;
        int req_cyc;
        nacks_left = nk;
        rises = 0; gap_bad = 0; done0_cnt = 0; done1_cnt = 0;
        ifa.data0 = d0; ifa.data1 = d1;
        ifa.req0 = r0; ifa.req1 = r1;
        req_cyc = cyc;
        wait_done(got);
        check("done_seen", 32'(got), 1);
        if (got) begin
            check("grant", 32'(ifa.grant), 32'(eg));
            check("ok", 32'(eg ? ifa.ok1 : ifa.ok0), 32'(eok));
            check("other_done", 32'(eg ? ifa.done0 : ifa.done1), 0);
            check("attempts", rises, eatt);
            check("retry_gap", gap_bad, 0);
            check("latency", rise_cyc - req_cyc, 1);
            check("data", 32'(first_data), 32'(eg ? d1 : d0));
            check("err_count", 32'(ifa.err_count), eerr);
            check("busy_report", 32'(ifa.busy), 1);
            if (eg) ifa.req1 = 1'b0; else ifa.req0 = 1'b0;
            @(negedge clk);
            check("done_width", 32'(ifa.done0 | ifa.done1), 0);
            if (r0 && r1) begin
                nacks_left = 0;
                rises = 0;
                gap_bad = 0;
                wait_done(got);
                check("done2_seen", 32'(got), 1);
                check("grant2", 32'(ifa.grant), 32'(!eg));
                check("ok2", 32'(eg ? ifa.ok0 : ifa.ok1), 1);
                check("attempts2", rises, 1);
                check("data2", 32'(first_data), 32'(eg ? d0 : d1));
            end
        end
        ifa.req0 = 1'b0;
        ifa.req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("done0_cnt", done0_cnt, 32'(r0));
        check("done1_cnt", done1_cnt, 32'(r1));
        check("busy_idle", 32'(ifa.busy), 0);
    endtask

    bit          m_last;
    int          m_err;
    bit          got_main;
    int          hi;
    int          w;
    int          fails;
    int          bad_ok;
    logic [23:0] rd0;
    logic [23:0] rd1;
    int          sel;
    int          rnk;
    bit          reg_;
    bit          rok;
    int          ratt;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 24'h34001a, 24'h000000, 0, 1'b0, 1'b1, 1, 0};
        vecs[1] = '{1'b0, 1'b1, 24'h111111, 24'haabbcc, 2, 1'b1, 1'b1, 3, 0};
        vecs[2] = '{1'b1, 1'b0, 24'h345566, 24'h222222, 5, 1'b0, 1'b0, 4, 1};
        vecs[3] = '{1'b1, 1'b1, 24'h340a0b, 24'h34c0de, 0, 1'b1, 1'b1, 1, 1};
        vecs[4] = '{1'b1, 1'b1, 24'h3401ff, 24'h340277, 4, 1'b1, 1'b0, 4, 2};
        vecs[5] = '{1'b0, 1'b1, 24'h333333, 24'h340300, 3, 1'b1, 1'b1, 4, 2};
        vecs[6] = '{1'b1, 1'b1, 24'h340404, 24'h340505, 0, 1'b0, 1'b1, 1, 2};

        reset = 1'b1;
        ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.data0 = '0; ifa.data1 = '0;
        ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.data0 = '0; ifb.data1 = '0;
        ifb.mend = 1'b0; ifb.mack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mgo", 32'(ifa.mgo), 0);
        check("rst_busy", 32'(ifa.busy), 0);
        check("rst_done", 32'({ifa.done0, ifa.done1, ifa.ok0, ifa.ok1}), 0);
        check("rst_grant", 32'(ifa.grant), 0);
        check("rst_data", 32'(ifa.i2c_data), 0);
        check("rst_err", 32'(ifa.err_count), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Contention: both held, each re-raised right after its done.
        nacks_left = 0;
        ifa.data0 = 24'h340011; ifa.data1 = 24'h340022;
        ifa.req0 = 1'b1; ifa.req1 = 1'b1;
        rises = 0;
        for (int i = 0; i < 4; i++) begin
            wait_done(got_main);
            check("cont_done", 32'(got_main), 1);
            check("cont_grant", 32'(ifa.grant), 32'(i % 2));
            check("cont_data", 32'(first_data), (i % 2) ? 32'h340022 : 32'h340011);
            rises = 0;
            if (ifa.grant) ifa.req1 = 1'b0; else ifa.req0 = 1'b0;
            @(negedge clk);
            ifa.req0 = 1'b1; ifa.req1 = 1'b1;
        end
        ifa.req0 = 1'b0; ifa.req1 = 1'b0;
        repeat (30) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            txn(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1, vecs[i].nk,
                vecs[i].eg, vecs[i].eok, vecs[i].eatt, vecs[i].eerr);
        end

        // Saturation: persistent NACKs with req0 held continuously.
        eng_delay = 2;
        nacks_left = 1000000;
        ifa.req0 = 1'b1;
        fails = 0; bad_ok = 0;
        for (int i = 0; i < 8000 && fails < 256; i++) begin
            @(negedge clk);
            if (ifa.done0) begin
                fails++;
                if (ifa.ok0) bad_ok++;
            end
        end
        ifa.req0 = 1'b0;
        check("sat_fails", fails, 256);
        check("sat_ok_low", bad_ok, 0);
        check("sat_err", 32'(ifa.err_count), 255);
        repeat (20) @(negedge clk);

        // Reset while requester 1 owns the engine.
        eng_delay = 20;
        nacks_left = 0;
        ifa.data1 = 24'h34beef;
        ifa.req1 = 1'b1;
        w = 0;
        while (!ifa.mgo && w < 10) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        check("pre_rst_grant", 32'(ifa.grant), 1);
        #3 reset = 1'b1;
        #1;
        check("arst_mgo", 32'(ifa.mgo), 0);
        check("arst_busy", 32'(ifa.busy), 0);
        check("arst_grant", 32'(ifa.grant), 0);
        check("arst_err", 32'(ifa.err_count), 0);
        ifa.req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        txn(1'b1, 1'b1, 24'h340101, 24'h340202, 0, 1'b0, 1'b1, 1, 0);

        // Random transactions against the rule-level model.
        m_last = 1'b1;
        m_err  = 0;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(1, 3);
            rnk = $urandom_range(0, 5);
            eng_delay = $urandom_range(1, 6);
            rd0 = 24'($urandom);
            rd1 = 24'($urandom);
            if (sel == 3) reg_ = !m_last;
            else          reg_ = (sel == 2);
            rok  = (rnk <= RETRY);
            ratt = rok ? rnk + 1 : RETRY + 1;
            if (!rok && m_err < 255) m_err++;
            txn(sel[0], sel[1], rd0, rd1, rnk, reg_, rok, ratt, m_err);
            m_last = (sel == 3) ? !reg_ : reg_;
        end

        // Timeout instance: the engine never answers.
        ifb.data0 = 24'h1a2b3c;
        ifb.req0 = 1'b1;
        for (int a = 0; a < 4; a++) begin
            w = 0; hi = 0;
            while (!ifb.mgo && w < 50) begin @(negedge clk); w++; end
            while (ifb.mgo && hi < 100) begin hi++; @(negedge clk); end
            check("tmo_high_len", hi, 16);
        end
        check("tmo_done", 32'(ifb.done0), 1);
        check("tmo_ok", 32'(ifb.ok0), 0);
        check("tmo_data", 32'(ifb.i2c_data), 32'h1a2b3c);
        check("tmo_err", 32'(ifb.err_count), 1);
        ifb.req0 = 1'b0;
        repeat (3) @(negedge clk);
        ifb.req0 = 1'b1;
        w = 0;
        while (!ifb.mgo && w < 50) begin @(negedge clk); w++; end
        repeat (15) @(negedge clk);
        ifb.mend = 1'b1;
        ifb.mack = 1'b1;
        @(negedge clk);
        ifb.mend = 1'b0;
        ifb.mack = 1'b0;
        check("tmo_edge_done", 32'(ifb.done0), 1);
        check("tmo_edge_ok", 32'(ifb.ok0), 1);
        check("tmo_edge_err", 32'(ifb.err_count), 1);
        ifb.req0 = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Shares the single I2C transfer engine (the `mgo`/`mend`/`mack` serial core) between two requesters: the power-up codec register loader and a runtime control path such as volume or mute updates. It grants one requester at a time with round-robin fairness and drives the engine's go/data handshake. It retries NACKed or timed-out transfers up to a limit and reports per-transaction success or failure to the owning requester. It sits between the requesters and the serial engine in the audio configuration path.

## Interface
- `RETRY_MAX`, 3: retries after the first attempt; total attempts = 1 + RETRY_MAX.
- `TIMEOUT`, 4095: cycles in WAIT without `mend` before the attempt counts as a NACK.
- `TW`, 12: timeout counter width; must hold TIMEOUT.
- `clk`  in  1  system clock (50 kHz I2C control clock domain).
- `reset`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  transaction request, held until the matching done.
- `data0` / `data1`  in  24  {8-bit device address/command, 8-bit register address, 8-bit data}; stable while req is high.
- `done0` / `done1`  out  1  one-cycle completion pulse to the owning requester.
- `ok0` / `ok1`  out  1  qualifies done: 1 = ACKed, 0 = failed after all attempts; valid only while done is high.
- `mgo`  out  1  go to the serial engine.
- `i2c_data`  out  24  word to the serial engine.
- `mend`  in  1  engine end-of-transfer; honoured only in WAIT.
- `mack`  in  1  engine acknowledge; sampled with `mend`.
- `busy`  out  1  high whenever the state is not IDLE.
- `grant`  out  1  index of the current or most recent owner.
- `err_count`  out  8  count of failed transactions; saturates at 255.

## Operation
- States: IDLE, WAIT, GAP, REPORT.
- **IDLE**
  - Inactive requester is ignored.
  - With one request active, grant that requester.
  - With both active, grant the requester not served last. The pointer after reset favours requester 0.
  - On grant: latch `grant`, load `i2c_data` from that requester's data, set `mgo`=1, clear the retry and timeout counters, go to WAIT.
- **WAIT**
  - `mgo` is held at 1.
  - The timeout counter increments every cycle.
  - On `mend`=1 with `mack`=1: clear `mgo`, set result = ok, go to REPORT.
  - On `mend`=1 with `mack`=0, or when the timeout counter reaches TIMEOUT−1 without `mend`: clear `mgo`.
    - If retries < RETRY_MAX: increment retries and go to GAP.
    - Otherwise: result = fail, increment `err_count` (saturating), go to REPORT.
  - If `mend` and timeout occur in the same cycle, `mend` wins.
- **GAP**
  - One cycle with `mgo`=0 so the engine re-arms.
  - Then set `mgo`=1, clear the timeout counter, return to WAIT.
  - `i2c_data` is unchanged.
- **REPORT**
  - `done<grant>`=1 and `ok<grant>`=result for exactly this cycle. The other requester's done stays 0.
  - Update the round-robin pointer to `grant`, then go to IDLE.
- Requester rule: drop `req` on the edge that samples done high. IDLE samples `req` on the following edge, so a properly dropped request is never re-issued. A request still held there is treated as a new transaction.
- `mend`/`mack` outside WAIT are ignored.
- Changes to `req`/`data` of the owning requester during a transaction are ignored; `i2c_data` is latched at grant.

## Timing
- Reset (asynchronous, immediate) values:
  - State IDLE; `mgo`, `done0`, `done1`, `ok0`, `ok1`, `busy`, `grant` = 0.
  - `i2c_data` = 0; `err_count` = 0; round-robin pointer favours requester 0.
  - Reset during WAIT abandons the transfer; `mgo` falls immediately.
- All outputs are registered.
- `req` high at edge k (state IDLE): `mgo`=1, `busy`=1 and `i2c_data` valid after edge k.
- `mend` high at edge m with ACK: `mgo`=0 after edge m; done/ok high for cycle m+1 only; IDLE after edge m+1.
- `mend` high at edge m with NACK and retry: `mgo`=0 for one cycle, then 1 again after edge m+1.
- Minimum turnaround: back-to-back grants are separated by at least one IDLE cycle.

## Test plan
- **Single request:** `req0`, `data0`=24'h34001a; model ACKs 20 cycles after `mgo` rises.
  - Required: `mgo` rises the edge after `req0`, `i2c_data`=24'h34001a.
  - Required: `done0`=`ok0`=1 for one cycle after `mend`; `done1` never pulses; `err_count`=0.
- **Contention:** `req0` and `req1` asserted together after reset and each re-asserted immediately after its done, for 4 transactions.
  - Required: grant order 0,1,0,1, with matching `i2c_data` each time.
- **Retry then success:** RETRY_MAX=3, model NACKs twice then ACKs.
  - Required: 3 `mgo` pulses, each separated by exactly one low cycle; single done with ok=1; `err_count`=0.
- **Persistent NACK:** model always NACKs.
  - Required: exactly 4 attempts; done with ok=0; `err_count`=1.
  - Required: 256 such failures leave `err_count`=255.
- **Timeout:** TIMEOUT=16, model never asserts `mend`.
  - Required: each attempt's `mgo` high phase ends after 16 WAIT cycles; after 4 attempts, done with ok=0.
  - Required: a `mend` forced on the 16th WAIT cycle of an attempt is honoured as end-of-transfer.
- **Reset mid-transfer:** `reset` pulsed while in WAIT owned by requester 1.
  - Required: `mgo`, `busy`, `grant`, `err_count` read 0 immediately.
  - Required: subsequent simultaneous requests grant requester 0 first.
